// File: rtl/tdc_readout_seq.sv
// Readout sequencer: walks the enabled TDC channels and serialises each result
// word as header + data bytes, closing every frame with a single 8'hFF byte.
module tdc_readout_seq #(
    parameter int NCH   = 16,
    parameter int DW    = 32,
    parameter int RDLAT = 1
) (
    input  logic           clk,
    input  logic           res,
    input  logic           start,
    input  logic           abort,
    input  logic [NCH-1:0] chan_mask,
    output logic [5:0]     address,
    output logic           rd_en,
    input  logic [DW-1:0]  rd_data,
    output logic [7:0]     tx_data,
    output logic           tx_start,
    input  logic           tx_busy,
    output logic           busy,
    output logic           done,
    output logic [2:0]     state_dbg
);

    localparam int NB = DW / 8;
    localparam int BW = (NB > 1) ? $clog2(NB) : 1;
    localparam logic [5:0]     LAST_CH  = 6'(NCH - 1);
    localparam logic [1:0]     LAT_LAST = 2'(RDLAT);
    localparam logic [BW-1:0]  LAST_B   = BW'(NB - 1);
    localparam logic [BW-1:0]  B_ONE    = BW'(1);
    localparam logic [NCH-1:0] ONE_HOT0 = NCH'(1);

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_SCAN = 3'd1,
        ST_READ = 3'd2,
        ST_HDR  = 3'd3,
        ST_DATA = 3'd4,
        ST_EOF  = 3'd5
    } state_t;

    state_t         state;
    logic [NCH-1:0] mask_q;
    logic [5:0]     cnt;
    logic [1:0]     lat_cnt;
    logic [BW-1:0]  bidx;
    logic [DW-1:0]  word_q;
    logic           guard;
    logic           guard_age;
    logic           eof_sent;
    logic           mask_hit;
    logic           can_send;

    // UART handshake: tx_start is a one-cycle strobe with tx_data valid in the
    // same cycle; the transmitter is ready again only once tx_busy is low and
    // the guard window (covering tx_busy's one-cycle rise delay) has closed.
    assign can_send  = !tx_busy && !guard && !tx_start;
    assign mask_hit  = |(mask_q & (ONE_HOT0 << cnt));
    assign state_dbg = state;

    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            state     <= ST_IDLE;
            mask_q    <= '0;
            cnt       <= '0;
            lat_cnt   <= '0;
            bidx      <= '0;
            word_q    <= '0;
            guard     <= 1'b0;
            guard_age <= 1'b0;
            eof_sent  <= 1'b0;
            address   <= '0;
            rd_en     <= 1'b0;
            tx_data   <= '0;
            tx_start  <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            rd_en    <= 1'b0;
            tx_start <= 1'b0;
            done     <= 1'b0;

            // Guard closes on the first busy cycle, or after two cycles if busy never rises
            if (guard) begin
                if (tx_busy || guard_age) begin
                    guard <= 1'b0;
                end else begin
                    guard_age <= 1'b1;
                end
            end

            if (abort && state != ST_IDLE && state != ST_EOF) begin
                state <= ST_EOF;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (start) begin
                            mask_q  <= chan_mask;
                            cnt     <= '0;
                            address <= '0;
                            busy    <= 1'b1;
                            state   <= ST_SCAN;
                        end
                    end
                    ST_SCAN: begin
                        if (mask_hit) begin
                            rd_en   <= 1'b1;
                            lat_cnt <= '0;
                            state   <= ST_READ;
                        end else if (cnt == LAST_CH) begin
                            state <= ST_EOF;
                        end else begin
                            cnt     <= cnt + 6'd1;
                            address <= cnt + 6'd1;
                        end
                    end
                    ST_READ: begin
                        if (lat_cnt == LAT_LAST) begin
                            word_q <= rd_data;
                            state  <= ST_HDR;
                        end else begin
                            lat_cnt <= lat_cnt + 2'd1;
                        end
                    end
                    ST_HDR: begin
                        if (can_send) begin
                            tx_start  <= 1'b1;
                            tx_data   <= {2'b10, cnt};
                            guard     <= 1'b1;
                            guard_age <= 1'b0;
                            bidx      <= '0;
                            state     <= ST_DATA;
                        end
                    end
                    ST_DATA: begin
                        if (can_send) begin
                            tx_start  <= 1'b1;
                            tx_data   <= word_q[DW-1 -: 8];
                            word_q    <= word_q << 8;
                            guard     <= 1'b1;
                            guard_age <= 1'b0;
                            if (bidx == LAST_B) begin
                                if (cnt == LAST_CH) begin
                                    state <= ST_EOF;
                                end else begin
                                    cnt     <= cnt + 6'd1;
                                    address <= cnt + 6'd1;
                                    state   <= ST_SCAN;
                                end
                            end else begin
                                bidx <= bidx + B_ONE;
                            end
                        end
                    end
                    ST_EOF: begin
                        // done follows the cycle in which the 8'hFF strobe is visible
                        if (eof_sent) begin
                            eof_sent <= 1'b0;
                            done     <= 1'b1;
                            busy     <= 1'b0;
                            state    <= ST_IDLE;
                        end else if (can_send) begin
                            tx_start  <= 1'b1;
                            tx_data   <= 8'hFF;
                            guard     <= 1'b1;
                            guard_age <= 1'b0;
                            eof_sent  <= 1'b1;
                        end
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_tdc_readout_seq.sv
// Randomized bench for tdc_readout_seq: byte-level frame model, TDC mux model
// with exact read latency, and a UART model with configurable busy length.
module tb_tdc_readout_seq;

    localparam int NCH   = 16;
    localparam int DW    = 32;
    localparam int RDLAT = 3;

    logic           clk;
    logic           res;
    logic           start;
    logic           abort;
    logic [NCH-1:0] chan_mask;
    logic [5:0]     address;
    logic           rd_en;
    logic [DW-1:0]  rd_data;
    logic [7:0]     tx_data;
    logic           tx_start;
    logic           tx_busy;
    logic           busy;
    logic           done;
    logic [2:0]     state_dbg;

    tdc_readout_seq #(.NCH(NCH), .DW(DW), .RDLAT(RDLAT)) u_dut (
        .clk       (clk),
        .res       (res),
        .start     (start),
        .abort     (abort),
        .chan_mask (chan_mask),
        .address   (address),
        .rd_en     (rd_en),
        .rd_data   (rd_data),
        .tx_data   (tx_data),
        .tx_start  (tx_start),
        .tx_busy   (tx_busy),
        .busy      (busy),
        .done      (done),
        .state_dbg (state_dbg)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // scoreboard and environment models
    logic [7:0]    exp_q[$];
    logic [DW-1:0] mem [0:63];
    int            tx_busy_len = 10;
    int            busy_left   = 0;
    int            done_cnt    = 0;
    int            tx_extra    = 0;
    int            cyc         = 0;
    int            last_tx_cyc = -100;
    logic          pipe_en   [RDLAT];
    logic [5:0]    pipe_addr [RDLAT];
    logic          valid_now = 1'b0;
    logic [5:0]    addr_now  = '0;
    logic          rd_en_prev = 1'b0;
    logic [5:0]    addr_prev  = '0;

    initial begin
        for (int i = 0; i < RDLAT; i++) begin
            pipe_en[i]   = 1'b0;
            pipe_addr[i] = '0;
        end
        for (int i = 0; i < 64; i++) mem[i] = '0;
        rd_data = '0;
        tx_busy = 1'b0;
    end

    // Values read at the posedge are those of the cycle that just ended.
    always @(posedge clk) begin
        cyc++;
        if (res) begin
            if (valid_now) check_eq("addr_hold", address, addr_now);
            if (rd_en) begin
                check_eq("addr_setup", address, addr_prev);
                check_eq("rd_en_width", rd_en_prev, 0);
            end
            if (tx_start) begin
                if (exp_q.size() == 0) tx_extra++;
                else check_eq("tx_byte", tx_data, exp_q.pop_front());
                check_eq("tx_spacing", (cyc - last_tx_cyc) >= 3, 1);
                last_tx_cyc = cyc;
            end
            if (done) done_cnt++;
        end
        if (tx_start) busy_left = tx_busy_len;
        else if (busy_left > 0) busy_left--;
        for (int i = RDLAT - 1; i > 0; i--) begin
            pipe_en[i]   = pipe_en[i-1];
            pipe_addr[i] = pipe_addr[i-1];
        end
        pipe_en[0]   = rd_en;
        pipe_addr[0] = address;
        rd_en_prev   = rd_en;
        addr_prev    = address;
        #1;
        valid_now = pipe_en[RDLAT-1];
        addr_now  = pipe_addr[RDLAT-1];
        rd_data   = valid_now ? mem[addr_now] : DW'($urandom());
        tx_busy   = (busy_left > 0);
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // Reference frame: per enabled channel ascending, header then bytes MSB first;
    // an abort after byte k keeps the first k bytes; 8'hFF always closes.
    task automatic build_exp(input logic [NCH-1:0] mask, input int abort_after);
        logic [7:0] full[$];
        for (int ch = 0; ch < NCH; ch++) begin
            if (mask[ch]) begin
                full.push_back(8'h80 + 8'(ch));
                for (int b = 0; b < DW / 8; b++)
                    full.push_back(8'(mem[ch] >> (DW - 8 * (b + 1))));
            end
        end
        exp_q.delete();
        for (int i = 0; i < full.size(); i++)
            if (abort_after == 0 || i < abort_after) exp_q.push_back(full[i]);
        exp_q.push_back(8'hFF);
    endtask

    task automatic randomize_mem();
        for (int i = 0; i < 64; i++) mem[i] = DW'($urandom());
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_address"},  address,  0);
        check_eq({tag, "_rd_en"},    rd_en,    0);
        check_eq({tag, "_tx_data"},  tx_data,  0);
        check_eq({tag, "_tx_start"}, tx_start, 0);
        check_eq({tag, "_busy"},     busy,     0);
        check_eq({tag, "_done"},     done,     0);
    endtask

    // Driver: one frame, optional abort after the n-th strobed byte, optional
    // mid-frame start pulse with a changed chan_mask.
    task automatic run_frame(input logic [NCH-1:0] mask, input int blen,
                             input int abort_after, input bit mid_start, output int lat);
        int  seen;
        bit  fin;
        tx_busy_len = blen;
        build_exp(mask, abort_after);
        tx_extra  = 0;
        done_cnt  = 0;
        chan_mask = mask;
        start     = 1'b1;
        tick();
        start = 1'b0;
        lat   = 1;
        check_eq("busy_after_start", busy, 1);
        seen = 0;
        fin  = 1'b0;
        while (!fin && lat < 6000) begin
            tick();
            lat++;
            abort = 1'b0;
            start = 1'b0;
            if (lat == 2 && mask[0]) check_eq("rd_en_t2", rd_en, 1);
            if (tx_start) begin
                seen++;
                if (seen == 1) check_eq("hdr_latency", lat >= 3 + RDLAT, 1);
                if (seen == abort_after) abort = 1'b1;
                if (mid_start && seen == 2) begin
                    start     = 1'b1;
                    chan_mask = ~mask;
                end
            end
            if (done) begin
                fin = 1'b1;
                check_eq("busy_at_done", busy, 0);
            end
        end
        abort = 1'b0;
        start = 1'b0;
        check_eq("done_seen", fin, 1);
        repeat (40) tick();
        check_eq("done_count", done_cnt, 1);
        check_eq("bytes_left", exp_q.size(), 0);
        check_eq("extra_bytes", tx_extra, 0);
        check_eq("busy_after_frame", busy, 0);
    endtask

    initial begin
        int lat;
        int seen;
        logic [NCH-1:0] m;
        int nbytes;

        res       = 1'b0;
        start     = 1'b0;
        abort     = 1'b0;
        chan_mask = '0;
        repeat (3) tick();
        check_reset_outputs("reset");
        #1 res = 1'b1;
        repeat (2) tick();

        // directed: two channels with known words
        mem[0] = 32'hA1B2C3D4;
        mem[2] = 32'h11223344;
        run_frame(16'h0005, 10, 0, 1'b0, lat);

        // empty mask: only 8'hFF, done within NCH+4 cycles
        run_frame('0, 10, 0, 1'b0, lat);
        check_eq("empty_done_latency", lat <= NCH + 4, 1);

        // last channel only
        randomize_mem();
        run_frame(16'h8000, 10, 0, 1'b0, lat);

        // abort during the second data byte of channel 0
        randomize_mem();
        run_frame(16'h0005, 10, 3, 1'b0, lat);

        // restart attempt and mask change mid-frame
        randomize_mem();
        run_frame(16'h0321, 6, 0, 1'b1, lat);

        // reset during DATA with the transmitter busy
        randomize_mem();
        build_exp(16'h0003, 0);
        tx_busy_len = 10;
        chan_mask   = 16'h0003;
        start       = 1'b1;
        tick();
        start = 1'b0;
        seen  = 0;
        for (int i = 0; i < 3000 && !(seen >= 2 && tx_busy); i++) begin
            tick();
            if (tx_start) seen++;
        end
        check_eq("rst_reached_data", seen >= 2 && tx_busy, 1);
        #1 res = 1'b0;
        #1 check_reset_outputs("async_reset");
        tick();
        tick();
        check_reset_outputs("held_reset");
        exp_q.delete();
        #1 res = 1'b1;
        repeat (2) tick();
        run_frame(16'h0003, 10, 0, 1'b0, lat);

        // randomized frames, some with an abort
        for (int k = 0; k < 10; k++) begin
            randomize_mem();
            m      = NCH'($urandom());
            nbytes = $countones(m) * (1 + DW / 8);
            if (k >= 7 && nbytes > 0)
                run_frame(m, $urandom_range(0, 12), $urandom_range(1, nbytes), 1'b0, lat);
            else
                run_frame(m, $urandom_range(0, 12), 0, (k % 3) == 1, lat);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
